// File: rtl/spi_ram_pkg.sv
// Shared definitions for the multi-port SPI front end to a single serial RAM:
// opcodes, per-port state encoding and the opcode decoder.
package spi_ram_pkg;

  localparam int BYTE_WIDTH = 8;

  localparam logic [BYTE_WIDTH-1:0] OP_READ_STATUS   = 8'h01;
  localparam logic [BYTE_WIDTH-1:0] OP_WRITE_COMMAND = 8'h02;
  localparam logic [BYTE_WIDTH-1:0] OP_ACCESS_RAM    = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    OPCODE,
    READ_STATUS,
    WRITE_COMMAND,
    RAM_REQ,
    RAM,
    DENIED,
    IGNORE
  } port_state_e;

  function automatic port_state_e decode_opcode(input logic [BYTE_WIDTH-1:0] op);
    port_state_e st;
    case (op)
      OP_READ_STATUS:   st = READ_STATUS;
      OP_WRITE_COMMAND: st = WRITE_COMMAND;
      OP_ACCESS_RAM:    st = RAM_REQ;
      default:          st = IGNORE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/spi_ram_arbiter_port.sv
// One SPI slave port: input synchronisers, edge strobes, opcode/byte FSM,
// RAM request handshake and MISO source selection.
module spi_slave_port
  import spi_ram_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  nss,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic                  ram_miso,
  input  logic [BYTE_WIDTH-1:0] status_byte,
  input  logic                  grant_win,
  output logic                  req,
  output logic                  nss_fwd,
  output logic                  sck_fwd,
  output logic                  mosi_fwd,
  output logic                  miso,
  output logic [BYTE_WIDTH-1:0] command,
  output logic                  command_valid
);

  localparam int CNT_W = $clog2(BYTE_WIDTH);

  logic [SYNC_STAGES-1:0] nss_sync_q, nss_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic nss_prev_q, nss_prev_d, sck_prev_q, sck_prev_d, mosi_prev_q, mosi_prev_d;
  logic nss_rise_q, nss_rise_d, nss_fall_q, nss_fall_d;
  logic sck_rise_q, sck_rise_d, sck_fall_q, sck_fall_d;

  port_state_e           state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [BYTE_WIDTH-1:0] rx_q, rx_d, tx_q, tx_d, cmd_q, cmd_d;
  logic                  miso_q, miso_d, cmd_valid_q, cmd_valid_d;
  logic [BYTE_WIDTH-1:0] rx_byte;
  logic                  byte_done;

  always_comb begin
    nss_sync_d  = {nss_sync_q[SYNC_STAGES-2:0], nss};
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    nss_prev_d  = nss_sync_q[SYNC_STAGES-1];
    sck_prev_d  = sck_sync_q[SYNC_STAGES-1];
    mosi_prev_d = mosi_sync_q[SYNC_STAGES-1];
    nss_rise_d  = nss_sync_q[SYNC_STAGES-1] & ~nss_prev_q;
    nss_fall_d  = ~nss_sync_q[SYNC_STAGES-1] & nss_prev_q;
    sck_rise_d  = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
    sck_fall_d  = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
  end

  // mosi_prev_q is aligned with the sck_rise_q strobe, so it is the sampled bit.
  assign rx_byte   = {mosi_prev_q, rx_q[BYTE_WIDTH-1:1]};
  assign byte_done = sck_rise_q && (bit_cnt_q == CNT_W'(BYTE_WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    if (nss_rise_q) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else if (nss_fall_q) begin
      state_d   = OPCODE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else begin
      if (sck_rise_q && state_q != IDLE) begin
        rx_d      = rx_byte;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
      case (state_q)
        OPCODE: begin
          miso_d = 1'b0;
          if (byte_done) begin
            state_d = decode_opcode(rx_byte);
            if (decode_opcode(rx_byte) == READ_STATUS) begin
              tx_d   = status_byte;
              miso_d = status_byte[0];
            end
          end
        end
        READ_STATUS: begin
          if (byte_done) begin
            tx_d   = status_byte;
            miso_d = status_byte[0];
          end else if (sck_fall_q) begin
            miso_d = tx_q[bit_cnt_q];
          end
        end
        WRITE_COMMAND: begin
          miso_d = 1'b0;
          if (byte_done) begin
            cmd_d       = rx_byte;
            cmd_valid_d = 1'b1;
          end
        end
        RAM_REQ: begin
          state_d = grant_win ? RAM : DENIED;
          miso_d  = grant_win ? ram_miso : 1'b1;
        end
        RAM:     miso_d = ram_miso;
        DENIED:  miso_d = 1'b1;
        default: miso_d = 1'b0;
      endcase
    end
  end

  // nss synchronisers reset low: a port whose select is held low across reset
  // sees no falling edge and so cannot start a session until re-selected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nss_sync_q  <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      nss_prev_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_prev_q <= 1'b0;
      nss_rise_q  <= 1'b0;
      nss_fall_q  <= 1'b0;
      sck_rise_q  <= 1'b0;
      sck_fall_q  <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      nss_sync_q  <= nss_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      nss_prev_q  <= nss_prev_d;
      sck_prev_q  <= sck_prev_d;
      mosi_prev_q <= mosi_prev_d;
      nss_rise_q  <= nss_rise_d;
      nss_fall_q  <= nss_fall_d;
      sck_rise_q  <= sck_rise_d;
      sck_fall_q  <= sck_fall_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign req           = (state_q == RAM_REQ) && !nss_rise_q;
  assign nss_fwd       = nss_prev_q;
  assign sck_fwd       = sck_prev_q;
  assign mosi_fwd      = mosi_prev_q;
  assign miso          = miso_q;
  assign command       = cmd_q;
  assign command_valid = cmd_valid_q;

endmodule

// File: rtl/spi_ram_arbiter.sv
// NUM_PORTS SPI slave ports sharing one serial RAM through a round-robin
// arbiter; the granted port's synchronised bus is registered onto the RAM pins.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             spi_nss,
  input  logic [NUM_PORTS-1:0]             spi_sck,
  input  logic [NUM_PORTS-1:0]             spi_mosi,
  output logic [NUM_PORTS-1:0]             spi_miso,
  output logic                             ram_nss,
  output logic                             ram_sck,
  output logic                             ram_mosi,
  input  logic                             ram_miso,
  input  logic [BYTE_WIDTH*NUM_PORTS-1:0]  status_in,
  output logic [BYTE_WIDTH*NUM_PORTS-1:0]  command_out,
  output logic [NUM_PORTS-1:0]             command_valid,
  output logic [NUM_PORTS-1:0]             ram_grant
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] req, win, nss_fwd, sck_fwd, mosi_fwd;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]     last_q, last_d;
  logic                 ram_nss_q, ram_nss_d, ram_sck_q, ram_sck_d, ram_mosi_q, ram_mosi_d;
  logic                 found;
  int                   idx;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      spi_slave_port #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_port (
        .clk          (clk),
        .reset_n      (reset_n),
        .nss          (spi_nss[gi]),
        .sck          (spi_sck[gi]),
        .mosi         (spi_mosi[gi]),
        .ram_miso     (ram_miso),
        .status_byte  (status_in[BYTE_WIDTH*gi +: BYTE_WIDTH]),
        .grant_win    (win[gi]),
        .req          (req[gi]),
        .nss_fwd      (nss_fwd[gi]),
        .sck_fwd      (sck_fwd[gi]),
        .mosi_fwd     (mosi_fwd[gi]),
        .miso         (spi_miso[gi]),
        .command      (command_out[BYTE_WIDTH*gi +: BYTE_WIDTH]),
        .command_valid(command_valid[gi])
      );
    end
  endgenerate

  // Only an idle bus can be granted, so requests during a session or in its
  // release clock are denied and ram_nss is high for at least one clock.
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    win     = '0;
    found   = 1'b0;
    idx     = 0;
    if (|grant_q) begin
      if (|(grant_q & nss_fwd)) grant_d = '0;
    end else begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        idx = int'(last_q) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (!found && req[idx]) begin
          found    = 1'b1;
          win[idx] = 1'b1;
          last_d   = PTR_W'(idx);
        end
      end
      grant_d = win;
    end
  end

  always_comb begin
    ram_nss_d  = 1'b1;
    ram_sck_d  = 1'b0;
    ram_mosi_d = 1'b0;
    if (|grant_d) begin
      ram_nss_d  = |(grant_d & nss_fwd);
      ram_sck_d  = |(grant_d & sck_fwd);
      ram_mosi_d = |(grant_d & mosi_fwd);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q    <= '0;
      last_q     <= PTR_W'(NUM_PORTS - 1);
      ram_nss_q  <= 1'b1;
      ram_sck_q  <= 1'b0;
      ram_mosi_q <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      last_q     <= last_d;
      ram_nss_q  <= ram_nss_d;
      ram_sck_q  <= ram_sck_d;
      ram_mosi_q <= ram_mosi_d;
    end
  end

  assign ram_grant = grant_q;
  assign ram_nss   = ram_nss_q;
  assign ram_sck   = ram_sck_q;
  assign ram_mosi  = ram_mosi_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench: table of command/status vectors, then RAM session, reset abort
// and arbitration race sequences against a behavioural serial RAM.
module tb_spi_ram_arbiter;

  localparam int NP   = 2;
  localparam int SS   = 2;
  localparam int HALF = 12;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NP-1:0]   spi_nss = '1;
  logic [NP-1:0]   spi_sck = '0;
  logic [NP-1:0]   spi_mosi = '0;
  logic [NP-1:0]   spi_miso;
  logic            ram_nss, ram_sck, ram_mosi;
  logic            ram_miso = 1'b0;
  logic [8*NP-1:0] status_in = '0;
  logic [8*NP-1:0] command_out;
  logic [NP-1:0]   command_valid, ram_grant;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.NUM_PORTS(NP), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_nss(spi_nss), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .ram_nss(ram_nss), .ram_sck(ram_sck), .ram_mosi(ram_mosi), .ram_miso(ram_miso),
    .status_in(status_in), .command_out(command_out),
    .command_valid(command_valid), .ram_grant(ram_grant)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int lat_last = 0;
  int vcnt0 = 0, vcnt1 = 0;
  int mon_bad = 0;
  logic          mon_en = 1'b0;
  logic [NP-1:0] mon_exp = '0;

  // Behavioural mode-0 RAM: streams ram_data LSB-first, logs received bytes.
  logic [7:0] ram_data [4];
  logic [7:0] rm_log [4];
  logic [7:0] rm_rxsh = '0;
  int   rm_pos = 0, rm_rxcnt = 0;
  logic rm_seen = 1'b0, rm_prev_nss = 1'b1, rm_prev_sck = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rm_prev_nss <= ram_nss;
    rm_prev_sck <= ram_sck;
    if (!ram_nss && rm_prev_nss) begin
      rm_pos   <= 0;
      rm_rxcnt <= 0;
      rm_seen  <= 1'b0;
      ram_miso <= ram_data[0][0];
    end else if (!ram_nss && ram_sck && !rm_prev_sck) begin
      rm_seen  <= 1'b1;
      rm_rxsh  <= {ram_mosi, rm_rxsh[7:1]};
      rm_rxcnt <= rm_rxcnt + 1;
      if (rm_rxcnt % 8 == 7) rm_log[(rm_rxcnt / 8) % 4] <= {ram_mosi, rm_rxsh[7:1]};
    end else if (!ram_nss && !ram_sck && rm_prev_sck && rm_seen) begin
      rm_pos   <= rm_pos + 1;
      ram_miso <= ram_data[((rm_pos + 1) / 8) % 4][(rm_pos + 1) % 8];
    end
  end

  always @(negedge clk) begin
    if (command_valid[0]) vcnt0 <= vcnt0 + 1;
    if (command_valid[1]) vcnt1 <= vcnt1 + 1;
    if (|command_valid) lat_last <= cyc - rise_cyc;
    if (mon_en && (ram_grant !== mon_exp || (mon_exp == '0 && ram_nss !== 1'b1)))
      mon_bad <= mon_bad + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic select(input logic [NP-1:0] mask);
    spi_nss = spi_nss & ~mask;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic deselect(input logic [NP-1:0] mask);
    repeat (HALF) @(negedge clk);
    spi_nss = spi_nss | mask;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic xfer(input logic [NP-1:0] mask, input logic [7:0] tx, input int nbits,
                      output logic [7:0] rx0, output logic [7:0] rx1);
    rx0 = '0;
    rx1 = '0;
    for (int b = 0; b < nbits; b++) begin
      spi_mosi = tx[b] ? (spi_mosi | mask) : (spi_mosi & ~mask);
      repeat (HALF) @(negedge clk);
      rx0[b] = spi_miso[0];
      rx1[b] = spi_miso[1];
      spi_sck  = spi_sck | mask;
      rise_cyc = cyc;
      repeat (HALF) @(negedge clk);
      spi_sck = spi_sck & ~mask;
    end
  endtask

  typedef struct {
    int          port;
    logic [7:0]  op;
    logic [7:0]  data;
    int          nbytes;
    logic [15:0] status;
    logic [7:0]  exp_rx;
    logic [15:0] exp_cmd;
    int          exp_v0;
    int          exp_v1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #(5000000);
    $display("FAIL watchdog: simulation did not reach its end, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0]    r0, r1, rp;
    logic [NP-1:0] mask;
    int v0s, v1s, bad_s, k;
    logic done;

    ram_data[0] = 8'h11; ram_data[1] = 8'h22; ram_data[2] = 8'h33; ram_data[3] = 8'h44;
    vecs[0] = '{0, 8'h02, 8'hA5, 1, 16'h0000, 8'h00, 16'h00A5, 1, 0};
    vecs[1] = '{1, 8'h01, 8'h00, 2, 16'h3C00, 8'h3C, 16'h00A5, 0, 0};
    vecs[2] = '{1, 8'h02, 8'h5A, 1, 16'h0000, 8'h00, 16'h5AA5, 0, 1};
    vecs[3] = '{0, 8'h07, 8'hFF, 1, 16'h00FF, 8'h00, 16'h5AA5, 0, 0};
    vecs[4] = '{0, 8'h01, 8'h00, 1, 16'hFFC3, 8'hC3, 16'h5AA5, 0, 0};
    vecs[5] = '{0, 8'h02, 8'h3E, 2, 16'h0000, 8'h00, 16'h5A3E, 2, 0};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_spi_miso", spi_miso, 0);
    check("rst_ram_nss", ram_nss, 1);
    check("rst_ram_sck", ram_sck, 0);
    check("rst_ram_mosi", ram_mosi, 0);
    check("rst_command_out", command_out, 0);
    check("rst_command_valid", command_valid, 0);
    check("rst_ram_grant", ram_grant, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Table: command writes, status reads, ignored opcode
    for (int i = 0; i < 6; i++) begin
      mask = NP'(1 << vecs[i].port);
      status_in = vecs[i].status;
      v0s = vcnt0;
      v1s = vcnt1;
      select(mask);
      xfer(mask, vecs[i].op, 8, r0, r1);
      for (int n = 0; n < vecs[i].nbytes; n++) begin
        xfer(mask, vecs[i].data, 8, r0, r1);
        rp = (vecs[i].port == 0) ? r0 : r1;
        $display("vec %0d port %0d op %02h byte %0d: miso %02h cmd %04h", i, vecs[i].port,
                 vecs[i].op, n, rp, command_out);
        check($sformatf("vec%0d_miso_byte%0d", i, n), rp, vecs[i].exp_rx);
      end
      deselect(mask);
      check($sformatf("vec%0d_command_out", i), command_out, vecs[i].exp_cmd);
      check($sformatf("vec%0d_valid0", i), vcnt0 - v0s, vecs[i].exp_v0);
      check($sformatf("vec%0d_valid1", i), vcnt1 - v1s, vecs[i].exp_v1);
      if (vecs[i].exp_v0 + vecs[i].exp_v1 > 0)
        check($sformatf("vec%0d_valid_latency", i), lat_last, SS + 2);
    end
    status_in = '0;

    // Partial command byte is discarded; next transaction decodes normally
    v0s = vcnt0;
    select(2'b01);
    xfer(2'b01, 8'h02, 8, r0, r1);
    xfer(2'b01, 8'hC9, 5, r0, r1);
    deselect(2'b01);
    $display("partial byte: cmd %04h valid pulses %0d", command_out, vcnt0 - v0s);
    check("partial_cmd", command_out, 16'h5A3E);
    check("partial_valid", vcnt0 - v0s, 0);
    select(2'b01);
    xfer(2'b01, 8'h02, 8, r0, r1);
    xfer(2'b01, 8'h77, 8, r0, r1);
    deselect(2'b01);
    $display("after partial: cmd %04h valid pulses %0d", command_out, vcnt0 - v0s);
    check("after_partial_cmd", command_out, 16'h5A77);
    check("after_partial_valid", vcnt0 - v0s, 1);

    // Port 0 RAM session
    select(2'b01);
    xfer(2'b01, 8'h03, 8, r0, r1);
    check("ram_grant_p0", ram_grant, 2'b01);
    check("ram_nss_active", ram_nss, 0);
    bad_s = mon_bad;
    mon_exp = 2'b01;
    mon_en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      xfer(2'b01, 8'hA1 + 8'(n * 8'h11), 8, r0, r1);
      $display("ram session byte %0d: port0 miso %02h", n, r0);
      check($sformatf("ram_read_byte%0d", n), r0, 8'h11 * (n + 1));
    end
    mon_en = 1'b0;
    check("ram_grant_held", mon_bad - bad_s, 0);
    for (int n = 0; n < 4; n++)
      check($sformatf("ram_mosi_byte%0d", n), rm_log[n], 8'hA1 + 8'(n * 8'h11));
    repeat (HALF) @(negedge clk);
    spi_nss[0] = 1'b1;
    done = 1'b0;
    k = 0;
    for (int i = 1; i <= 10 && !done; i++) begin
      @(posedge clk);
      #1;
      if (ram_nss) begin
        done = 1'b1;
        k = i;
      end
    end
    $display("ram_nss release after %0d clk", k);
    check("ram_nss_release_in_time", done && k <= SS + 2, 1);
    repeat (4) @(negedge clk);
    check("ram_grant_released", ram_grant, 0);
    check("ram_sck_idle", ram_sck, 0);
    repeat (2 * HALF) @(negedge clk);

    // Reset mid RAM session
    select(2'b01);
    xfer(2'b01, 8'h03, 8, r0, r1);
    check("pre_reset_grant", ram_grant, 2'b01);
    xfer(2'b01, 8'h00, 4, r0, r1);
    reset_n = 1'b0;
    #1;
    $display("reset mid session: ram_nss %0b grant %02b miso %02b", ram_nss, ram_grant, spi_miso);
    check("abort_ram_nss", ram_nss, 1);
    check("abort_ram_grant", ram_grant, 0);
    check("abort_spi_miso", spi_miso, 0);
    check("abort_command_out", command_out, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bad_s = mon_bad;
    mon_exp = 2'b00;
    mon_en = 1'b1;
    xfer(2'b01, 8'h03, 8, r0, r1);
    xfer(2'b01, 8'h00, 8, r0, r1);
    mon_en = 1'b0;
    check("no_grant_without_nss_fall", mon_bad - bad_s, 0);
    deselect(2'b01);

    // Simultaneous requests: port 0 first, then port 1
    for (int round = 0; round < 2; round++) begin
      select(2'b11);
      xfer(2'b11, 8'h03, 8, r0, r1);
      check($sformatf("race%0d_grant", round), ram_grant, (round == 0) ? 2'b01 : 2'b10);
      xfer(2'b11, 8'h00, 8, r0, r1);
      $display("race %0d: grant %02b port0 miso %02h port1 miso %02h", round, ram_grant, r0, r1);
      check($sformatf("race%0d_port0", round), r0, (round == 0) ? 8'h11 : 8'hFF);
      check($sformatf("race%0d_port1", round), r1, (round == 0) ? 8'hFF : 8'h11);
      deselect(2'b11);
      check($sformatf("race%0d_released", round), ram_grant, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Clocked, parametrised successor to the shared-serial-RAM core logic. It terminates NUM_PORTS independent SPI slave ports (MCU, coprocessor, further masters). Each port decodes an opcode byte and then serves command writes, status reads, or a pass-through session to the single serial RAM. Concurrent RAM requests are arbitrated round-robin, and a denied requester is told explicitly instead of getting undefined data.

## Interface
Parameters:
- NUM_PORTS, 2: number of SPI slave ports (1..8).
- SYNC_STAGES, 2: synchroniser flops on every nss/sck/mosi input (≥2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- spi_nss  input  NUM_PORTS  per-port chip select, active low.
- spi_sck  input  NUM_PORTS  per-port SPI clock, mode 0.
- spi_mosi  input  NUM_PORTS  per-port data in.
- spi_miso  output  NUM_PORTS  per-port data out, registered.
- ram_nss, ram_sck, ram_mosi  output  1 each  RAM master bus, registered.
- ram_miso  input  1  RAM data out.
- status_in  input  8*NUM_PORTS  status byte readable by port i at [8i+7:8i].
- command_out  output  8*NUM_PORTS  last command byte written by port i.
- command_valid  output  NUM_PORTS  one-clk pulse when command_out[i] updates.
- ram_grant  output  NUM_PORTS  one-hot owner of the RAM bus; all zero when idle.

## Operation
- Bytes are LSB-first. mosi is sampled on sync'd sck rise. miso changes on sync'd sck fall, bit 0 driven from nss fall.
- Per-port FSM:
  - IDLE → OPCODE on nss fall. The counter clears.
  - After 8 bits in OPCODE, the next state follows the opcode: 0x01 READ_STATUS, 0x02 WRITE_COMMAND, 0x03 RAM_REQ, any other value IGNORE.
  - nss rise from any state → IDLE. A partial byte is discarded and produces no command_valid.
- READ_STATUS: status_in[i] is snapshotted at each byte boundary and shifted out LSB-first. Multiple bytes are allowed.
- WRITE_COMMAND: every completed byte loads command_out[i] and pulses command_valid[i].
- RAM_REQ: the port raises its request on the clk after opcode completion.
  - Granted → RAM state. ram_nss/sck/mosi track the port's synchronised nss/sck/mosi, and spi_miso[i] tracks ram_miso.
  - Bus busy → DENIED. miso drives 1 (reads 0xFF) until nss rises, and the request is dropped with no queueing.
- IGNORE: miso 0.
- Arbiter:
  - If several requests arrive in the same clk, the winner is the lowest index strictly after the last granted port, wrapping.
  - The pointer updates on grant and resets to NUM_PORTS-1, so port 0 wins first.
  - The grant is released when the owner's sync'd nss goes high.
  - ram_nss stays high for ≥1 clk before any new grant.
- While no port is granted: ram_nss=1, ram_sck=0, ram_mosi=0.
- Reset values: spi_miso=0, ram_nss=1, ram_sck=0, ram_mosi=0, command_out=0, command_valid=0, ram_grant=0, all FSMs IDLE.
- Reset asserted mid-transfer aborts every session immediately. The bus stays idle until each port sees a fresh nss fall after reset release.

## Timing
- Input to internal edge: SYNC_STAGES+1 clk.
- Edge to registered output: +1 clk.
- RAM pass-through forward (spi_* → ram_*): SYNC_STAGES+2 clk.
- ram_miso → spi_miso: 1 clk.
- Requirement: SCK high and low phases each ≥ 2·(SYNC_STAGES+3) clk, so round-trip data is valid before the master samples.
- Grant: request at clk n → ram_grant and ram_nss=0 at n+1. The first forwarded sck edge is the master's next one.
- command_valid: SYNC_STAGES+2 clk after the 8th sck rise.

## Structure
- Package spi_ram_pkg:
  - opcode constants OP_READ_STATUS, OP_WRITE_COMMAND, OP_ACCESS_RAM;
  - port state enum (IDLE, OPCODE, READ_STATUS, WRITE_COMMAND, RAM_REQ, RAM, DENIED, IGNORE);
  - BYTE_WIDTH=8.
- Sub-module spi_slave_port, instantiated NUM_PORTS times, contains:
  - synchronisers, edge detect, bit counter, shift register, FSM;
  - request/grant handshake and miso mux.
- The top level holds the round-robin arbiter and the RAM output mux/registers.

## Test plan
- Port 0 sends 0x02 then 0xA5 → command_out[7:0]=0xA5, one command_valid[0] pulse. Port 1 outputs are unchanged.
- status_in[15:8]=0x3C, port 1 sends 0x01 then clocks 16 bits → miso bytes 0x3C, 0x3C.
- Port 0 sends 0x03 then a 4-byte RAM read; the RAM model returns 0x11,0x22,0x33,0x44.
  - ram_grant=01 throughout; port 0 reads back 0x11,0x22,0x33,0x44.
  - ram_nss returns to 1 within SYNC_STAGES+2 clk of nss rise.
- Ports 0 and 1 finish 0x03 in the same clk after reset → port 0 granted, port 1 reads 0xFF. After release, repeat the same race → port 1 granted.
- nss rises after 5 bits of a WRITE_COMMAND byte → no command_valid, command_out unchanged. The next transaction decodes its opcode correctly.
- reset_n pulsed low mid RAM session → ram_nss=1, ram_grant=0, spi_miso=0 asynchronously. No grant occurs until a new nss fall.
